// File: rtl/bank_request_tagger.sv
// Request tagger ahead of one bank scheduler: stamps legal requests with an
// ID and a global cycle count, queues them in a FIFO and drives a stat tap.
module bank_request_tagger #(
    parameter int RANK   = 0,
    parameter int BANK   = 0,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_rd_en,
    input  logic                       in_wr_en,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_rd_en,
    output logic                       out_wr_en,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [ID_W-1:0]            out_request_id,
    output logic [63:0]                out_cycle_stamp,
    output logic [63:0]                global_cycle,
    output logic                       stat_req_fire,
    output logic                       stat_rd_en,
    output logic                       stat_wr_en,
    output logic [ADDR_W-1:0]          stat_addr,
    output logic [ID_W-1:0]            stat_request_id,
    output logic [63:0]                stat_global_cycle,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                illegal_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RANK < 0 || BANK < 0) begin : g_bad_param
        $error("bank_request_tagger: DEPTH must be a power of two >= 2, RANK/BANK >= 0");
    end

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [63:0]       stamp;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [ID_W-1:0]  next_id;
    logic             accept, legal, push, pop;

    // in_ready depends on occupancy alone: a full FIFO refuses even while popping
    assign in_ready  = (occupancy < OCC_W'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign accept    = in_valid & in_ready;
    assign legal     = in_rd_en ^ in_wr_en;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;

    assign new_entry = '{rd: in_rd_en, wr: in_wr_en, addr: in_addr, id: next_id, stamp: global_cycle};

    // Head fields read as zero while empty so reset/flush leaves no stale data visible
    assign head            = out_valid ? mem[rd_ptr] : '0;
    assign out_rd_en       = head.rd;
    assign out_wr_en       = head.wr;
    assign out_addr        = head.addr;
    assign out_request_id  = head.id;
    assign out_cycle_stamp = head.stamp;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            global_cycle      <= '0;
            next_id           <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            occupancy         <= '0;
            illegal_count     <= '0;
            stat_req_fire     <= 1'b0;
            stat_rd_en        <= 1'b0;
            stat_wr_en        <= 1'b0;
            stat_addr         <= '0;
            stat_request_id   <= '0;
            stat_global_cycle <= '0;
        end else begin
            global_cycle  <= global_cycle + 64'd1;
            stat_req_fire <= push;
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                next_id           <= next_id + 1'b1;
                stat_rd_en        <= new_entry.rd;
                stat_wr_en        <= new_entry.wr;
                stat_addr         <= new_entry.addr;
                stat_request_id   <= new_entry.id;
                stat_global_cycle <= new_entry.stamp;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occupancy <= occupancy + 1'b1;
            else if (!push && pop) occupancy <= occupancy - 1'b1;
            if (accept && !legal && illegal_count != 16'hFFFF)
                illegal_count <= illegal_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_bank_request_tagger.sv
// Directed bench for bank_request_tagger: reset, single read, fill/drain,
// full-while-popping, illegal requests and mid-stream reset.
module tb_bank_request_tagger;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_rd_en = 1'b0, in_wr_en = 1'b0, out_ready = 1'b0;
    logic [31:0] in_addr = '0;
    logic        in_ready, out_valid, out_rd_en, out_wr_en;
    logic [31:0] out_addr, out_request_id, stat_addr, stat_request_id;
    logic [63:0] out_cycle_stamp, global_cycle, stat_global_cycle;
    logic        stat_req_fire, stat_rd_en, stat_wr_en;
    logic [2:0]  occupancy;
    logic [15:0] illegal_count;
    int          errors = 0;
    int          checks = 0;

    bank_request_tagger #(.RANK(0), .BANK(0), .DEPTH(4), .ADDR_W(32), .ID_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd_en(in_rd_en), .in_wr_en(in_wr_en),
        .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_en(out_rd_en), .out_wr_en(out_wr_en),
        .out_addr(out_addr), .out_request_id(out_request_id), .out_cycle_stamp(out_cycle_stamp),
        .global_cycle(global_cycle),
        .stat_req_fire(stat_req_fire), .stat_rd_en(stat_rd_en), .stat_wr_en(stat_wr_en),
        .stat_addr(stat_addr), .stat_request_id(stat_request_id), .stat_global_cycle(stat_global_cycle),
        .occupancy(occupancy), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_rd_en = 0; in_wr_en = 0; in_addr = '0; out_ready = 0;
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        #13;
        checks++; if (global_cycle !== 64'd0) begin errors++; $display("FAIL rst_cycle: got %0d exp 0", global_cycle); end
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo: occ %0d valid %0b exp 0 0", occupancy, out_valid); end
        checks++; if (stat_req_fire !== 1'b0 || stat_request_id !== 32'd0 || illegal_count !== 16'd0) begin
            errors++; $display("FAIL rst_stat: fire %0b id %0d ill %0d exp 0 0 0", stat_req_fire, stat_request_id, illegal_count); end
        checks++; if (out_request_id !== 32'd0 || out_addr !== 32'd0) begin errors++; $display("FAIL rst_out: id %0d addr %0h exp 0 0", out_request_id, out_addr); end
        tick();
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (stat_req_fire !== 1'b0) begin errors++; $display("FAIL idle_fire: got %0b exp 0 at %0d", stat_req_fire, i); end
        end
        checks++; if (global_cycle !== 64'd10) begin errors++; $display("FAIL idle_cycle: got %0d exp 10", global_cycle); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_hs: valid %0b ready %0b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_single_read();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (global_cycle !== 64'd5) begin errors++; $display("FAIL sr_pre_cycle: got %0d exp 5", global_cycle); end
        in_valid = 1; in_rd_en = 1; in_wr_en = 0; in_addr = 32'h100;
        tick();
        in_valid = 0; in_rd_en = 0;
        checks++; if (stat_req_fire !== 1'b1 || stat_rd_en !== 1'b1 || stat_wr_en !== 1'b0) begin
            errors++; $display("FAIL sr_stat_flags: fire %0b rd %0b wr %0b exp 1 1 0", stat_req_fire, stat_rd_en, stat_wr_en); end
        checks++; if (stat_request_id !== 32'd0 || stat_global_cycle !== 64'd5 || stat_addr !== 32'h100) begin
            errors++; $display("FAIL sr_stat_fields: id %0d cyc %0d addr %0h exp 0 5 100", stat_request_id, stat_global_cycle, stat_addr); end
        checks++; if (out_valid !== 1'b1 || out_rd_en !== 1'b1 || out_wr_en !== 1'b0 || out_addr !== 32'h100) begin
            errors++; $display("FAIL sr_head: v %0b rd %0b wr %0b addr %0h exp 1 1 0 100", out_valid, out_rd_en, out_wr_en, out_addr); end
        checks++; if (out_request_id !== 32'd0 || out_cycle_stamp !== 64'd5) begin
            errors++; $display("FAIL sr_head_tag: id %0d stamp %0d exp 0 5", out_request_id, out_cycle_stamp); end
        tick();
        checks++; if (stat_req_fire !== 1'b0 || stat_request_id !== 32'd0 || stat_global_cycle !== 64'd5) begin
            errors++; $display("FAIL sr_stat_hold: fire %0b id %0d cyc %0d exp 0 0 5", stat_req_fire, stat_request_id, stat_global_cycle); end
        checks++; if (out_valid !== 1'b1 || out_cycle_stamp !== 64'd5) begin errors++; $display("FAIL sr_head_stable: v %0b stamp %0d exp 1 5", out_valid, out_cycle_stamp); end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL sr_pop: occ %0d v %0b exp 0 0", occupancy, out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1; in_wr_en = 1; in_rd_en = 0;
        for (int i = 0; i < 5; i++) begin
            in_addr = 32'h200 + 32'(i);
            if (i < 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b exp 1 at %0d", in_ready, i); end
            end
            tick();
            if (i < 4) begin
                checks++; if (stat_req_fire !== 1'b1 || stat_request_id !== 32'(i)) begin
                    errors++; $display("FAIL b2b_stat: fire %0b id %0d exp 1 %0d", stat_req_fire, stat_request_id, i); end
            end
        end
        checks++; if (occupancy !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: occ %0d ready %0b exp 4 0", occupancy, in_ready); end
        checks++; if (stat_req_fire !== 1'b0) begin errors++; $display("FAIL b2b_held: fire %0b exp 0", stat_req_fire); end
        checks++; if (out_request_id !== 32'd0 || out_addr !== 32'h200 || out_wr_en !== 1'b1) begin
            errors++; $display("FAIL b2b_head: id %0d addr %0h wr %0b exp 0 200 1", out_request_id, out_addr, out_wr_en); end
        // Full and popping in the same cycle: the pop wins, the held write waits
        out_ready = 1;
        tick();
        checks++; if (occupancy !== 3'd3 || stat_req_fire !== 1'b0) begin errors++; $display("FAIL full_pop: occ %0d fire %0b exp 3 0", occupancy, stat_req_fire); end
        checks++; if (out_request_id !== 32'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_head: id %0d ready %0b exp 1 1", out_request_id, in_ready); end
        tick();
        in_valid = 0; in_wr_en = 0;
        checks++; if (occupancy !== 3'd3 || stat_req_fire !== 1'b1 || stat_request_id !== 32'd4) begin
            errors++; $display("FAIL pushpop: occ %0d fire %0b id %0d exp 3 1 4", occupancy, stat_req_fire, stat_request_id); end
        for (int k = 2; k <= 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_request_id !== 32'(k) || out_addr !== 32'h200 + 32'(k)) begin
                errors++; $display("FAIL drain: v %0b id %0d addr %0h exp 1 %0d %0h", out_valid, out_request_id, out_addr, k, 32'h200 + k); end
            tick();
        end
        out_ready = 0;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: occ %0d v %0b exp 0 0", occupancy, out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        in_valid = 1; in_rd_en = 1; in_wr_en = 1; in_addr = 32'h300;
        tick();
        checks++; if (illegal_count !== 16'd1 || stat_req_fire !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL ill_both: cnt %0d fire %0b occ %0d exp 1 0 0", illegal_count, stat_req_fire, occupancy); end
        in_rd_en = 0; in_wr_en = 0;
        tick();
        checks++; if (illegal_count !== 16'd2 || stat_req_fire !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL ill_none: cnt %0d fire %0b occ %0d exp 2 0 0", illegal_count, stat_req_fire, occupancy); end
        in_rd_en = 1; in_addr = 32'h304;
        tick();
        in_valid = 0; in_rd_en = 0;
        checks++; if (stat_req_fire !== 1'b1 || stat_request_id !== 32'd0 || occupancy !== 3'd1 || illegal_count !== 16'd2) begin
            errors++; $display("FAIL ill_legal: fire %0b id %0d occ %0d cnt %0d exp 1 0 1 2", stat_req_fire, stat_request_id, occupancy, illegal_count); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_valid = 1; in_rd_en = 1; in_wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            in_addr = 32'h400 + 32'(i);
            tick();
        end
        in_valid = 0; in_rd_en = 0;
        checks++; if (occupancy !== 3'd3 || stat_request_id !== 32'd2) begin errors++; $display("FAIL mr_fill: occ %0d id %0d exp 3 2", occupancy, stat_request_id); end
        #2;
        reset = 0;
        #1;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || global_cycle !== 64'd0) begin
            errors++; $display("FAIL mr_async: occ %0d v %0b cyc %0d exp 0 0 0", occupancy, out_valid, global_cycle); end
        tick();
        reset = 1;
        in_valid = 1; in_wr_en = 1; in_addr = 32'h500;
        tick();
        in_valid = 0; in_wr_en = 0;
        checks++; if (stat_req_fire !== 1'b1 || stat_request_id !== 32'd0 || stat_global_cycle !== 64'd0 || global_cycle !== 64'd1) begin
            errors++; $display("FAIL mr_restart: fire %0b id %0d stamp %0d cyc %0d exp 1 0 0 1", stat_req_fire, stat_request_id, stat_global_cycle, global_cycle); end
        checks++; if (occupancy !== 3'd1 || out_addr !== 32'h500 || out_request_id !== 32'd0) begin
            errors++; $display("FAIL mr_head: occ %0d addr %0h id %0d exp 1 500 0", occupancy, out_addr, out_request_id); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bank_request_tagger.md
Name: bank_request_tagger

Overview:
Sits directly upstream of the per-bank scheduler's input statistics tap and request port. Accepts raw read/write requests from the rank/bank decoder and assigns each legal request a monotonically increasing request ID and an arrival cycle stamp from a free-running 64-bit global cycle counter. Tagged requests are buffered in a small FIFO toward the bank scheduler. A registered one-shot statistics tap (fire, rd, wr, addr, id, cycle) is driven for the downstream per-bank CSV logger.

Parameters:
RANK, 0, rank index of the owning bank (identification only).
BANK, 0, bank index of the owning bank (identification only).
DEPTH, 4, FIFO entries; power of two, minimum 2.
ADDR_W, 32, request address width.
ID_W, 32, request ID width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream request valid.
in_ready  out  1  tagger can accept a request.
in_rd_en  in  1  request is a read.
in_wr_en  in  1  request is a write.
in_addr  in  ADDR_W  request address.
out_valid  out  1  FIFO head valid toward the scheduler.
out_ready  in  1  scheduler accepts the head.
out_rd_en  out  1  head read flag.
out_wr_en  out  1  head write flag.
out_addr  out  ADDR_W  head address.
out_request_id  out  ID_W  head request ID.
out_cycle_stamp  out  64  global_cycle value at head acceptance.
global_cycle  out  64  free-running cycle counter.
stat_req_fire  out  1  one-cycle pulse per accepted legal request.
stat_rd_en  out  1  rd flag of the pulsed request.
stat_wr_en  out  1  wr flag of the pulsed request.
stat_addr  out  ADDR_W  address of the pulsed request.
stat_request_id  out  ID_W  ID of the pulsed request.
stat_global_cycle  out  64  cycle stamp of the pulsed request.
occupancy  out  clog2(DEPTH)+1  current FIFO entry count.
illegal_count  out  16  count of rejected illegal requests.

Behaviour:
- Reset (reset=0, asynchronous): global_cycle=0, next ID=0, FIFO empty, occupancy=0, out_valid=0, all out_* and stat_* fields=0, stat_req_fire=0, illegal_count=0. Reset mid-operation discards all FIFO contents. IDs restart at 0.
- global_cycle increments by 1 on every clock edge out of reset; wraps from 2^64-1 to 0.
- Accept handshake: accept = in_valid & in_ready. in_ready = (occupancy < DEPTH). in_ready is combinational from occupancy only and does not depend on out_ready, so a full FIFO never accepts, even while popping.
- Legal request: in_rd_en XOR in_wr_en.
  - Legal accept: push {rd, wr, addr, next ID, global_cycle sampled in the accept cycle}. Next ID increments by 1 and wraps at 2^ID_W.
  - Illegal accept (rd_en==wr_en): request consumed, nothing pushed, ID not incremented, illegal_count increments, saturating at 0xFFFF. stat_req_fire stays 0.
- Latency: a request accepted in cycle N is visible at the head no earlier than cycle N+1. There is no combinational in-to-out bypass.
- out_valid = (occupancy != 0). out_* fields reflect the head entry and are stable while out_valid=1 and out_ready=0. Pop occurs on out_valid & out_ready.
- Push and pop in the same cycle: occupancy unchanged, pointers both advance. Pop when empty is ignored.
- Pointers wrap modulo DEPTH.
- Stat tap is registered: a legal accept in cycle N drives stat_req_fire=1 in cycle N+1 with stat_* equal to the pushed entry (stat_global_cycle = stamp from cycle N). Without a legal accept in cycle N, stat_req_fire=0 in N+1 and the other stat_* fields hold their last values.
- Ordering: strict FIFO. out_request_id values leave in increasing order, mod 2^ID_W.

Test Plan:
- Reset release, then idle 10 cycles -> global_cycle=10, out_valid=0, in_ready=1, stat_req_fire never asserted.
- Single read at cycle 5 (addr 0x100) -> stat pulse at cycle 6 with id=0, rd=1, wr=0, cycle=5. out_valid=1 from cycle 6 with the same fields. Pop at cycle 8 -> occupancy 0.
- DEPTH+1 back-to-back writes with out_ready=0 -> first 4 accepted with ids 0..3, in_ready=0 at occupancy 4, fifth request held. Raise out_ready -> ids 0,1,2,3,4 emerge in order.
- Full FIFO with simultaneous in_valid and out_ready -> no accept that cycle, occupancy 4→3, next cycle accepted with id 4.
- Requests with rd=wr=1, then rd=wr=0, then a legal read -> illegal_count=2, no stat pulses for the first two, legal read gets id=0.
- Assert reset mid-stream with 3 entries queued -> occupancy=0, out_valid=0 immediately. After release the next legal request gets id=0, and global_cycle restarts from 0.
